// File: rtl/gauss_pass_sequencer.sv
// rtl/gauss_pass_sequencer.sv - two-pass separable 1-2-1 Gaussian filter sequencer
// Issues 3 tap reads per pixel, waits out the BRAM latency, then writes one result.
module gauss_pass_sequencer #(
  parameter int IMG_LOG2 = 7,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  disp_req,
  output logic                  rd_en,
  output logic                  rd_sel,
  output logic [2*IMG_LOG2-1:0] rd_addr,
  output logic                  tap_valid,
  output logic [1:0]            tap_idx,
  output logic                  wr_en,
  output logic                  wr_sel,
  output logic [2*IMG_LOG2-1:0] wr_addr,
  output logic                  pass,
  output logic                  busy,
  output logic                  done
);

  localparam logic [IMG_LOG2-1:0] MAX_COORD = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_SWITCH = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                       state, state_nxt;
  logic [IMG_LOG2-1:0]          row, col;
  logic [1:0]                   k;
  logic [1:0]                   wcnt;
  logic                         pass_q;
  logic [READ_LAT-1:0]          pipe_v;
  logic [READ_LAT-1:0][1:0]     pipe_k;
  logic                         last_pix;
  logic                         wait_done;
  logic [IMG_LOG2-1:0]          tap_coord;

  // Neighbour coordinate for tap t, replicating the edge pixel instead of wrapping.
  function automatic logic [IMG_LOG2-1:0] tap_step(input logic [IMG_LOG2-1:0] c,
                                                    input logic [1:0] t);
    case (t)
      2'd0:    tap_step = (c == '0) ? c : c - 1'b1;
      2'd2:    tap_step = (c == MAX_COORD) ? c : c + 1'b1;
      default: tap_step = c;
    endcase
  endfunction

  assign last_pix  = (row == MAX_COORD) && (col == MAX_COORD);
  assign wait_done = (wcnt == 2'(READ_LAT - 1));
  assign tap_coord = tap_step(pass_q ? row : col, k);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ISSUE;
      S_ISSUE:  if (!disp_req && k == 2'd2) state_nxt = S_WAIT;
      S_WAIT:   if (wait_done) state_nxt = S_WRITE;
      S_WRITE: begin
        if (!last_pix)   state_nxt = S_ISSUE;
        else if (pass_q) state_nxt = S_DONE;
        else             state_nxt = S_SWITCH;
      end
      S_SWITCH: state_nxt = S_ISSUE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row    <= '0;
      col    <= '0;
      k      <= '0;
      wcnt   <= '0;
      pass_q <= 1'b0;
      pipe_v <= '0;
      pipe_k <= '0;
    end else begin
      pipe_v[0] <= rd_en;
      pipe_k[0] <= k;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_k[i] <= pipe_k[i-1];
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            row    <= '0;
            col    <= '0;
            k      <= '0;
            pass_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (!disp_req) begin
            if (k == 2'd2) begin
              k    <= '0;
              wcnt <= '0;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_WAIT:  wcnt <= wcnt + 1'b1;
        S_WRITE: begin
          if (!last_pix) begin
            if (col == MAX_COORD) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_SWITCH: begin
          pass_q <= 1'b1;
          row    <= '0;
          col    <= '0;
        end
        S_DONE:  pass_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    done      = 1'b0;
    rd_sel    = pass_q;
    wr_sel    = pass_q;
    pass      = pass_q;
    busy      = (state != S_IDLE);
    tap_valid = pipe_v[READ_LAT-1];
    tap_idx   = pipe_v[READ_LAT-1] ? pipe_k[READ_LAT-1] : 2'd0;
    case (state)
      S_ISSUE: begin
        rd_en = !disp_req;
        if (!disp_req) rd_addr = pass_q ? {tap_coord, col} : {row, tap_coord};
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {row, col};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gauss_pass_sequencer.sv
// tb/tb_gauss_pass_sequencer.sv - bench for gauss_pass_sequencer
// BRAM model plus image-level golden 1-2-1 filter on a 16x16 image, READ_LAT 1 and 3.
module tb_gauss_pass_sequencer;
  localparam int L  = 4;
  localparam int S  = 16;
  localparam int N  = S * S;
  localparam int AW = 2 * L;

  typedef struct {
    int addr;
    int sel;
    int k;
    int cyc;
  } rd_t;

  logic clk = 1'b0;
  logic rst, start1, start3, disp_req;
  int   sel;

  logic a_rd_en, a_rd_sel, a_tap_valid, a_wr_en, a_wr_sel, a_pass, a_busy, a_done;
  logic b_rd_en, b_rd_sel, b_tap_valid, b_wr_en, b_wr_sel, b_pass, b_busy, b_done;
  logic [AW-1:0] a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr;
  logic [1:0]    a_tap_idx, b_tap_idx;

  logic o_rd_en, o_rd_sel, o_tap_valid, o_wr_en, o_wr_sel, o_pass, o_busy, o_done;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [1:0]    o_tap_idx;

  gauss_pass_sequencer #(.IMG_LOG2(L), .READ_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .disp_req(disp_req),
    .rd_en(a_rd_en), .rd_sel(a_rd_sel), .rd_addr(a_rd_addr),
    .tap_valid(a_tap_valid), .tap_idx(a_tap_idx),
    .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_addr(a_wr_addr),
    .pass(a_pass), .busy(a_busy), .done(a_done));

  gauss_pass_sequencer #(.IMG_LOG2(L), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .disp_req(disp_req),
    .rd_en(b_rd_en), .rd_sel(b_rd_sel), .rd_addr(b_rd_addr),
    .tap_valid(b_tap_valid), .tap_idx(b_tap_idx),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_addr(b_wr_addr),
    .pass(b_pass), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  always_comb begin
    if (sel == 3) begin
      o_rd_en = b_rd_en;  o_rd_sel = b_rd_sel;  o_rd_addr = b_rd_addr;
      o_tap_valid = b_tap_valid;  o_tap_idx = b_tap_idx;
      o_wr_en = b_wr_en;  o_wr_sel = b_wr_sel;  o_wr_addr = b_wr_addr;
      o_pass = b_pass;  o_busy = b_busy;  o_done = b_done;
    end else begin
      o_rd_en = a_rd_en;  o_rd_sel = a_rd_sel;  o_rd_addr = a_rd_addr;
      o_tap_valid = a_tap_valid;  o_tap_idx = a_tap_idx;
      o_wr_en = a_wr_en;  o_wr_sel = a_wr_sel;  o_wr_addr = a_wr_addr;
      o_pass = a_pass;  o_busy = a_busy;  o_done = a_done;
    end
  end

  int passed = 0;
  int total  = 0;

  int in_img[N], mid_img[N], out_img[N], gold_out[N];
  int rd_log[6*N], rd_cyc[6*N];
  rd_t rq[$];
  int g_done_cyc, g_done_cnt, g_seq_err, g_tap_err, g_overlap, g_quiet_err, g_busy_err;
  int g_wr_cnt, g_rd_cnt, g_stall_rd, g_first_wr_cyc, g_pix3_wr_cyc;

  function automatic int cl(input int x);
    return (x < 0) ? 0 : ((x > S - 1) ? S - 1 : x);
  endfunction

  task automatic new_image();
    int h[N];
    for (int i = 0; i < N; i++) in_img[i] = $urandom_range(0, 255);
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        h[r*S+c] = (in_img[r*S+cl(c-1)] + 2*in_img[r*S+c] + in_img[r*S+cl(c+1)]) / 4;
    for (int r = 0; r < S; r++)
      for (int c = 0; c < S; c++)
        gold_out[r*S+c] = (h[cl(r-1)*S+c] + 2*h[r*S+c] + h[cl(r+1)*S+c]) / 4;
  endtask

  function automatic int image_errors();
    int e = 0;
    for (int i = 0; i < N; i++) if (out_img[i] != gold_out[i]) e++;
    return e;
  endfunction

  // One full two-pass run; the BRAMs and filter datapath are modelled from the DUT strobes.
  task automatic run(input int rl, input int stall_at, input int stall_len, input bit rand_stall);
    int n, limit, p, idx, ps, pix, kk, r, c, ex, res;
    int taps[3];
    rd_t e;
    sel = rl;
    rq.delete();
    g_done_cyc = -1; g_done_cnt = 0; g_seq_err = 0; g_tap_err = 0; g_overlap = 0;
    g_quiet_err = 0; g_busy_err = 0; g_wr_cnt = 0; g_rd_cnt = 0; g_stall_rd = 0;
    g_first_wr_cyc = -1; g_pix3_wr_cyc = -1;
    taps = '{0, 0, 0};
    for (int i = 0; i < N; i++) begin mid_img[i] = -1; out_img[i] = -1; end
    p = 4 + rl;
    limit = 6 * N * p + 200;
    @(negedge clk);
    disp_req = 1'b0;
    if (rl == 1) start1 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    n = 1;
    while (n < limit) begin
      disp_req = rand_stall ? ($urandom_range(0, 3) == 0) : (n >= stall_at && n < stall_at + stall_len);
      #1;
      if (o_rd_en) begin
        idx = g_rd_cnt; ps = idx / (3*N); pix = (idx / 3) % N; kk = idx % 3;
        r = pix / S; c = pix % S;
        ex = (ps == 0) ? r*S + cl(c+kk-1) : cl(r+kk-1)*S + c;
        if (ps > 1 || o_rd_addr != ex || o_rd_sel != ps[0]) g_seq_err++;
        if (idx < 6*N) begin rd_log[idx] = int'(o_rd_addr); rd_cyc[idx] = n; end
        e.addr = int'(o_rd_addr); e.sel = int'(o_rd_sel); e.k = kk; e.cyc = n;
        rq.push_back(e);
        if (n >= stall_at && n < stall_at + stall_len) g_stall_rd++;
        g_rd_cnt++;
      end else if (o_rd_addr != '0) g_quiet_err++;
      if (o_tap_valid) begin
        if (rq.size() == 0) g_tap_err++;
        else begin
          e = rq.pop_front();
          if (n - e.cyc != rl || int'(o_tap_idx) != e.k) g_tap_err++;
          taps[o_tap_idx] = e.sel ? mid_img[e.addr] : in_img[e.addr];
        end
      end
      if (o_wr_en) begin
        if (int'(o_wr_addr) != g_wr_cnt % N || int'(o_wr_sel) != g_wr_cnt / N) g_seq_err++;
        res = (taps[0] + 2*taps[1] + taps[2]) >> 2;
        if (o_wr_sel) out_img[o_wr_addr] = res; else mid_img[o_wr_addr] = res;
        if (g_wr_cnt == 0) g_first_wr_cyc = n;
        if (g_wr_cnt == 3) g_pix3_wr_cyc = n;
        g_wr_cnt++;
      end else if (o_wr_addr != '0) g_quiet_err++;
      if (o_rd_en && o_wr_en) g_overlap++;
      if (!o_busy) g_busy_err++;
      if (o_done) begin
        g_done_cnt++;
        g_done_cyc = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    disp_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; disp_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({a_rd_en, a_rd_sel, a_rd_addr, a_tap_valid, a_tap_idx, a_wr_en, a_wr_sel, a_wr_addr,
         a_pass, a_busy, a_done} !== '0)
      $display("FAIL reset_rl1: outputs not all zero (rd_en=%b wr_en=%b busy=%b)", a_rd_en, a_wr_en, a_busy);
    else passed++;
    total++;
    if ({b_rd_en, b_rd_sel, b_rd_addr, b_tap_valid, b_tap_idx, b_wr_en, b_wr_sel, b_wr_addr,
         b_pass, b_busy, b_done} !== '0)
      $display("FAIL reset_rl3: outputs not all zero (rd_en=%b wr_en=%b busy=%b)", b_rd_en, b_wr_en, b_busy);
    else passed++;
  endtask

  task automatic test_full_rl1();
    int exp_done;
    new_image();
    run(1, -1, 0, 1'b0);
    exp_done = 2 * N * 5 + 2;
    total++; if (g_done_cyc != exp_done) $display("FAIL rl1_done_cycle: got %0d expected %0d", g_done_cyc, exp_done); else passed++;
    total++; if (g_done_cnt != 1) $display("FAIL rl1_done_count: got %0d expected 1", g_done_cnt); else passed++;
    total++; if (rd_log[0] != 0 || rd_log[1] != 0 || rd_log[2] != 1)
      $display("FAIL rl1_first_taps: got %0d,%0d,%0d expected 0,0,1", rd_log[0], rd_log[1], rd_log[2]); else passed++;
    total++; if (rd_cyc[0] != 1 || rd_cyc[2] != 3)
      $display("FAIL rl1_first_tap_cycles: got %0d..%0d expected 1..3", rd_cyc[0], rd_cyc[2]); else passed++;
    total++; if (g_first_wr_cyc != 5) $display("FAIL rl1_first_write_cycle: got %0d expected 5", g_first_wr_cyc); else passed++;
    total++; if (rd_log[285] != 'h5E || rd_log[286] != 'h5F || rd_log[287] != 'h5F)
      $display("FAIL clamp_col_edge: got %0h,%0h,%0h expected 5e,5f,5f", rd_log[285], rd_log[286], rd_log[287]); else passed++;
    total++; if (rd_log[795] != 'h09 || rd_log[796] != 'h09 || rd_log[797] != 'h19)
      $display("FAIL clamp_row_edge: got %0h,%0h,%0h expected 9,9,19", rd_log[795], rd_log[796], rd_log[797]); else passed++;
    total++; if (g_seq_err != 0) $display("FAIL rl1_addr_sequence: got %0d errors expected 0", g_seq_err); else passed++;
    total++; if (g_tap_err != 0) $display("FAIL rl1_tap_timing: got %0d errors expected 0", g_tap_err); else passed++;
    total++; if (g_wr_cnt != 2 * N) $display("FAIL rl1_write_count: got %0d expected %0d", g_wr_cnt, 2 * N); else passed++;
    total++; if (g_overlap != 0 || g_quiet_err != 0)
      $display("FAIL rl1_strobe_hygiene: got overlap=%0d stray_addr=%0d expected 0,0", g_overlap, g_quiet_err); else passed++;
    total++; if (g_busy_err != 0) $display("FAIL rl1_busy: got %0d low cycles expected 0", g_busy_err); else passed++;
    total++; if (image_errors() != 0) $display("FAIL rl1_image: got %0d bad pixels expected 0", image_errors()); else passed++;
  endtask

  task automatic test_disp_stall();
    int exp_done;
    new_image();
    run(1, 2 + 3 * 5, 7, 1'b0);
    exp_done = 2 * N * 5 + 2 + 7;
    total++; if (g_done_cyc != exp_done) $display("FAIL stall_done_cycle: got %0d expected %0d", g_done_cyc, exp_done); else passed++;
    total++; if (g_stall_rd != 0) $display("FAIL stall_rd_en: got %0d reads during stall expected 0", g_stall_rd); else passed++;
    total++; if (rd_log[10] != 3 || rd_cyc[10] != 24)
      $display("FAIL stall_reissue: got addr %0d at cycle %0d expected addr 3 at cycle 24", rd_log[10], rd_cyc[10]); else passed++;
    total++; if (g_pix3_wr_cyc != 27) $display("FAIL stall_write_delay: got %0d expected 27", g_pix3_wr_cyc); else passed++;
    total++; if (g_seq_err != 0 || g_tap_err != 0)
      $display("FAIL stall_sequence: got seq=%0d tap=%0d errors expected 0,0", g_seq_err, g_tap_err); else passed++;
    total++; if (image_errors() != 0) $display("FAIL stall_image: got %0d bad pixels expected 0", image_errors()); else passed++;
  endtask

  task automatic test_read_lat3();
    int exp_done;
    new_image();
    run(3, -1, 0, 1'b0);
    exp_done = 2 * N * 7 + 2;
    total++; if (g_done_cyc != exp_done) $display("FAIL rl3_done_cycle: got %0d expected %0d", g_done_cyc, exp_done); else passed++;
    total++; if (g_tap_err != 0 || rq.size() != 0)
      $display("FAIL rl3_tap_timing: got %0d errors, %0d undrained expected 0,0", g_tap_err, rq.size()); else passed++;
    total++; if (g_first_wr_cyc != 7) $display("FAIL rl3_first_write_cycle: got %0d expected 7", g_first_wr_cyc); else passed++;
    total++; if (g_seq_err != 0 || g_overlap != 0)
      $display("FAIL rl3_sequence: got seq=%0d overlap=%0d expected 0,0", g_seq_err, g_overlap); else passed++;
    total++; if (image_errors() != 0) $display("FAIL rl3_image: got %0d bad pixels expected 0", image_errors()); else passed++;
  endtask

  task automatic test_random_stall();
    new_image();
    run(3, -1, 0, 1'b1);
    total++; if (g_done_cnt != 1 || g_done_cyc < 2 * N * 7 + 2)
      $display("FAIL rand_done: got count %0d at cycle %0d expected 1 at >= %0d", g_done_cnt, g_done_cyc, 2 * N * 7 + 2); else passed++;
    total++; if (g_seq_err != 0 || g_tap_err != 0 || g_overlap != 0)
      $display("FAIL rand_sequence: got seq=%0d tap=%0d overlap=%0d expected 0", g_seq_err, g_tap_err, g_overlap); else passed++;
    total++; if (image_errors() != 0) $display("FAIL rand_image: got %0d bad pixels expected 0", image_errors()); else passed++;
  endtask

  task automatic test_restart();
    int n, rc, wr, err, pass_mid, exp_wr, act;
    sel = 1; wr = 0; err = 0; act = 0; pass_mid = 0;
    rc = N * 5 + 52;
    @(negedge clk);
    disp_req = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (n <= rc) begin
      start1 = (n == 100);
      rst = (n == rc);
      #1;
      if (o_wr_en) begin
        if (int'(o_wr_addr) != wr % N || int'(o_wr_sel) != wr / N) err++;
        wr++;
      end
      if (n == N * 5 + 10) pass_mid = int'(o_pass);
      @(negedge clk);
      n++;
    end
    rst = 1'b0; start1 = 1'b0;
    #1;
    exp_wr = N + (rc - N * 5 - 1) / 5;
    total++; if (wr != exp_wr || err != 0)
      $display("FAIL restart_ignored_start: got %0d writes (%0d bad) expected %0d (0 bad)", wr, err, exp_wr); else passed++;
    total++; if (pass_mid != 1) $display("FAIL restart_pass1: got %0d expected 1", pass_mid); else passed++;
    total++;
    if ({o_rd_en, o_rd_sel, o_rd_addr, o_tap_valid, o_tap_idx, o_wr_en, o_wr_sel, o_wr_addr,
         o_pass, o_busy, o_done} !== '0)
      $display("FAIL restart_reset_outputs: got busy=%b pass=%b tap_valid=%b expected all zero", o_busy, o_pass, o_tap_valid);
    else passed++;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (o_rd_en || o_wr_en || o_done || o_busy) act++;
    end
    total++; if (act != 0) $display("FAIL restart_idle: got %0d active cycles expected 0", act); else passed++;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    #1;
    total++; if (o_rd_en !== 1'b1 || o_rd_addr !== '0 || o_rd_sel !== 1'b0 || o_pass !== 1'b0)
      $display("FAIL restart_first_tap: got rd_en=%b addr=%0h sel=%b pass=%b expected 1,0,0,0", o_rd_en, o_rd_addr, o_rd_sel, o_pass);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; disp_req = 1'b0; sel = 1;
    test_reset();
    test_full_rl1();
    test_disp_stall();
    test_read_lat3();
    test_random_stall();
    test_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
